// File: rtl/rf_pwr_seq.sv
// Half-duplex RF power sequencer: arbitrates RX/TX for shared bias/PLL and steps supplies.
// Define RF_SEQ_RR_EN for round-robin tie-break; default build gives RX fixed priority.
module rf_pwr_seq #(
    parameter int CW      = 16,
    parameter int T_BIAS  = 10,
    parameter int T_PLL   = 50,
    parameter int T_CHAIN = 20,
    parameter int T_OFF   = 5
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       PU_RX,
    input  logic       PU_TX,
    output logic       EN_BIAS,
    output logic       EN_PLL,
    output logic       EN_LNA,
    output logic       EN_PA,
    output logic       RDY_RX,
    output logic       RDY_TX,
    output logic       GNT_TX,
    output logic       BUSY,
    output logic [2:0] STATE
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_BIAS   = 3'd1;
    localparam logic [2:0] S_PLL    = 3'd2;
    localparam logic [2:0] S_CHAIN  = 3'd3;
    localparam logic [2:0] S_ACTIVE = 3'd4;
    localparam logic [2:0] S_OFF    = 3'd5;

    localparam logic [CW-1:0] L_BIAS  = CW'(T_BIAS - 1);
    localparam logic [CW-1:0] L_PLL   = CW'(T_PLL - 1);
    localparam logic [CW-1:0] L_CHAIN = CW'(T_CHAIN - 1);
    localparam logic [CW-1:0] L_OFF   = CW'(T_OFF - 1);

    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_en_bias;
    logic          r_en_pll;
    logic          r_en_lna;
    logic          r_en_pa;
    logic          r_rdy_rx;
    logic          r_rdy_tx;
    logic          r_gnt_tx;

    logic          w_any;
    logic          w_pick_tx;
    logic          w_req_g;
    logic          w_zero;

`ifdef RF_SEQ_RR_EN
    logic          r_last_tx;

    always_comb begin
        w_pick_tx = PU_TX & ~PU_RX;
        if (PU_RX && PU_TX) begin
            w_pick_tx = ~r_last_tx;
        end
    end

    // Last-grant flag starts at TX so RX wins the first tie.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_last_tx <= 1'b1;
        end else if (w_any && ((r_state == S_IDLE) ||
                     ((r_state == S_OFF) && w_zero))) begin
            r_last_tx <= w_pick_tx;
        end
    end
`else
    always_comb begin
        w_pick_tx = PU_TX & ~PU_RX;
    end
`endif

    assign w_any   = PU_RX | PU_TX;
    assign w_req_g = r_gnt_tx ? PU_TX : PU_RX;
    assign w_zero  = (r_cnt == '0);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_en_bias <= 1'b0;
            r_en_pll  <= 1'b0;
            r_en_lna  <= 1'b0;
            r_en_pa   <= 1'b0;
            r_rdy_rx  <= 1'b0;
            r_rdy_tx  <= 1'b0;
            r_gnt_tx  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state   <= S_BIAS;
                        r_cnt     <= L_BIAS;
                        r_en_bias <= 1'b1;
                        r_gnt_tx  <= w_pick_tx;
                    end
                end
                S_BIAS: begin
                    if (!w_req_g) begin
                        r_state  <= S_OFF;
                        r_cnt    <= L_OFF;
                        r_en_lna <= 1'b0;
                        r_en_pa  <= 1'b0;
                        r_rdy_rx <= 1'b0;
                        r_rdy_tx <= 1'b0;
                    end else if (w_zero) begin
                        r_state  <= S_PLL;
                        r_cnt    <= L_PLL;
                        r_en_pll <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_PLL: begin
                    if (!w_req_g) begin
                        r_state  <= S_OFF;
                        r_cnt    <= L_OFF;
                        r_en_lna <= 1'b0;
                        r_en_pa  <= 1'b0;
                        r_rdy_rx <= 1'b0;
                        r_rdy_tx <= 1'b0;
                    end else if (w_zero) begin
                        r_state  <= S_CHAIN;
                        r_cnt    <= L_CHAIN;
                        r_en_lna <= ~r_gnt_tx;
                        r_en_pa  <= r_gnt_tx;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_CHAIN: begin
                    if (!w_req_g) begin
                        r_state  <= S_OFF;
                        r_cnt    <= L_OFF;
                        r_en_lna <= 1'b0;
                        r_en_pa  <= 1'b0;
                        r_rdy_rx <= 1'b0;
                        r_rdy_tx <= 1'b0;
                    end else if (w_zero) begin
                        r_state  <= S_ACTIVE;
                        r_rdy_rx <= ~r_gnt_tx;
                        r_rdy_tx <= r_gnt_tx;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (!w_req_g) begin
                        r_state  <= S_OFF;
                        r_cnt    <= L_OFF;
                        r_en_lna <= 1'b0;
                        r_en_pa  <= 1'b0;
                        r_rdy_rx <= 1'b0;
                        r_rdy_tx <= 1'b0;
                    end
                end
                S_OFF: begin
                    if (!w_zero) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (!w_any) begin
                        r_state   <= S_IDLE;
                        r_en_bias <= 1'b0;
                        r_en_pll  <= 1'b0;
                    end else if (r_en_pll) begin
                        // Shared supplies still up: warm switch straight to the chain.
                        r_state  <= S_CHAIN;
                        r_cnt    <= L_CHAIN;
                        r_gnt_tx <= w_pick_tx;
                        r_en_lna <= ~w_pick_tx;
                        r_en_pa  <= w_pick_tx;
                    end else begin
                        r_state   <= S_BIAS;
                        r_cnt     <= L_BIAS;
                        r_gnt_tx  <= w_pick_tx;
                        r_en_bias <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_cnt     <= '0;
                    r_en_bias <= 1'b0;
                    r_en_pll  <= 1'b0;
                    r_en_lna  <= 1'b0;
                    r_en_pa   <= 1'b0;
                    r_rdy_rx  <= 1'b0;
                    r_rdy_tx  <= 1'b0;
                end
            endcase
        end
    end

    assign EN_BIAS = r_en_bias;
    assign EN_PLL  = r_en_pll;
    assign EN_LNA  = r_en_lna;
    assign EN_PA   = r_en_pa;
    assign RDY_RX  = r_rdy_rx;
    assign RDY_TX  = r_rdy_tx;
    assign GNT_TX  = r_gnt_tx;
    assign BUSY    = (r_state != S_IDLE);
    assign STATE   = r_state;

endmodule

// File: tb/tb_rf_pwr_seq.sv
// Scoreboard bench for rf_pwr_seq: expected output vectors queued per edge.
// Output vector: {EN_BIAS,EN_PLL,EN_LNA,EN_PA,RDY_RX,RDY_TX,GNT_TX,BUSY,STATE}.
module tb_rf_pwr_seq;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       PU_RX;
    logic       PU_TX;
    logic       EN_BIAS;
    logic       EN_PLL;
    logic       EN_LNA;
    logic       EN_PA;
    logic       RDY_RX;
    logic       RDY_TX;
    logic       GNT_TX;
    logic       BUSY;
    logic [2:0] STATE;

`ifdef RF_SEQ_RR_EN
    localparam logic G2 = 1'b1;
`else
    localparam logic G2 = 1'b0;
`endif

    typedef struct {
        int          cyc;
        logic [10:0] v;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    rf_pwr_seq dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .PU_RX  (PU_RX),
        .PU_TX  (PU_TX),
        .EN_BIAS(EN_BIAS),
        .EN_PLL (EN_PLL),
        .EN_LNA (EN_LNA),
        .EN_PA  (EN_PA),
        .RDY_RX (RDY_RX),
        .RDY_TX (RDY_TX),
        .GNT_TX (GNT_TX),
        .BUSY   (BUSY),
        .STATE  (STATE)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] x);
        n_chk++;
        if (o !== x) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, o, x, cyc);
        end
    endtask

    function automatic logic [10:0] obs();
        return {EN_BIAS, EN_PLL, EN_LNA, EN_PA, RDY_RX, RDY_TX,
                GNT_TX, BUSY, STATE};
    endfunction

    function automatic logic [10:0] O(input logic b, input logic p,
                                      input logic l, input logic a,
                                      input logic rx, input logic tx,
                                      input logic g, input logic [2:0] st);
        return {b, p, l, a, rx, tx, g, (st != 3'd0), st};
    endfunction

    task automatic exp_at(input int c, input string tag,
                          input logic [10:0] v);
        exp_t e;
        e.cyc = c;
        e.v   = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge CLK);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (cyc > 0) begin
            chk("mutex", {30'd0, EN_LNA & EN_PA, RDY_RX & RDY_TX}, 32'd0);
        end
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc < cyc) chk({"late_", e.tag}, cyc, e.cyc);
            else chk(e.tag, {21'd0, obs()}, {21'd0, e.v});
        end
    end

    initial begin
        #50000;
        n_fail++;
        $display("FAIL watchdog: got timeout want finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        int e;
        int d;
        RST_N = 1'b0;
        PU_RX = 1'b0;
        PU_TX = 1'b0;
        repeat (2) @(negedge CLK);
        chk("reset", {21'd0, obs()}, 32'd0);
        RST_N = 1'b1;
        @(negedge CLK);

        // RX power-up, full sequence
        c = cyc; PU_RX = 1'b1; e = c + 1;
        exp_at(e,      "s1_bias",      O(1,0,0,0,0,0,0,3'd1));
        exp_at(e + 9,  "s1_bias_end",  O(1,0,0,0,0,0,0,3'd1));
        exp_at(e + 10, "s1_pll",       O(1,1,0,0,0,0,0,3'd2));
        exp_at(e + 59, "s1_pll_end",   O(1,1,0,0,0,0,0,3'd2));
        exp_at(e + 60, "s1_chain",     O(1,1,1,0,0,0,0,3'd3));
        exp_at(e + 79, "s1_chain_end", O(1,1,1,0,0,0,0,3'd3));
        exp_at(e + 80, "s1_active",    O(1,1,1,0,1,0,0,3'd4));
        exp_at(e + 84, "s1_hold",      O(1,1,1,0,1,0,0,3'd4));
        wait_cyc(e + 85);

        // RX release to shutdown
        c = cyc; PU_RX = 1'b0; d = c + 1;
        exp_at(d,     "s2_off",     O(1,1,0,0,0,0,0,3'd5));
        exp_at(d + 4, "s2_off_end", O(1,1,0,0,0,0,0,3'd5));
        exp_at(d + 5, "s2_idle",    O(0,0,0,0,0,0,0,3'd0));
        wait_cyc(d + 7);

        // RX active, TX requested, RX dropped: warm switch
        c = cyc; PU_RX = 1'b1; e = c + 1;
        exp_at(e + 80, "s3_rx_act", O(1,1,1,0,1,0,0,3'd4));
        wait_cyc(e + 82);
        c = cyc; PU_TX = 1'b1;
        exp_at(c + 1, "s3_nopreempt", O(1,1,1,0,1,0,0,3'd4));
        wait_cyc(c + 2);
        PU_RX = 1'b0; d = c + 3;
        exp_at(d,      "s3_off",       O(1,1,0,0,0,0,0,3'd5));
        exp_at(d + 4,  "s3_off_end",   O(1,1,0,0,0,0,0,3'd5));
        exp_at(d + 5,  "s3_warm",      O(1,1,0,1,0,0,1,3'd3));
        exp_at(d + 24, "s3_chain_end", O(1,1,0,1,0,0,1,3'd3));
        exp_at(d + 25, "s3_tx_act",    O(1,1,0,1,0,1,1,3'd4));
        wait_cyc(d + 27);
        c = cyc; PU_TX = 1'b0; d = c + 1;
        exp_at(d,     "s3_tx_off",   O(1,1,0,0,0,0,1,3'd5));
        exp_at(d + 5, "s3_idle_gnt", O(0,0,0,0,0,0,1,3'd0));
        wait_cyc(d + 7);

        // Ties at IDLE and at OFF expiry
        c = cyc; PU_RX = 1'b1; PU_TX = 1'b1; e = c + 1;
        exp_at(e, "s4_tie1", O(1,0,0,0,0,0,0,3'd1));
        wait_cyc(e + 2);
        PU_RX = 1'b0; d = e + 3;
        exp_at(d, "s4_off", O(1,0,0,0,0,0,0,3'd5));
        wait_cyc(d + 2);
        PU_RX = 1'b1;
        exp_at(d + 4, "s4_off_end", O(1,0,0,0,0,0,0,3'd5));
        exp_at(d + 5, "s4_tie2",    O(1,0,0,0,0,0,G2,3'd1));
        wait_cyc(d + 7);
        PU_RX = 1'b0; PU_TX = 1'b0;
        exp_at(d + 8,  "s4_drop", O(1,0,0,0,0,0,G2,3'd5));
        exp_at(d + 13, "s4_idle", O(0,0,0,0,0,0,G2,3'd0));
        wait_cyc(d + 15);

        // Async reset in PLL, then restart
        c = cyc; PU_RX = 1'b1; e = c + 1;
        exp_at(e + 28, "s5_pll", O(1,1,0,0,0,0,0,3'd2));
        wait_cyc(e + 29);
        RST_N = 1'b0;
        #1 chk("s5_async_rst", {21'd0, obs()}, 32'd0);
        #1 RST_N = 1'b1;
        e = e + 30;
        exp_at(e,      "s5_bias",      O(1,0,0,0,0,0,0,3'd1));
        exp_at(e + 10, "s5_pll2",      O(1,1,0,0,0,0,0,3'd2));
        exp_at(e + 60, "s5_chain",     O(1,1,1,0,0,0,0,3'd3));
        exp_at(e + 79, "s5_chain_end", O(1,1,1,0,0,0,0,3'd3));
        exp_at(e + 80, "s5_active",    O(1,1,1,0,1,0,0,3'd4));
        wait_cyc(e + 82);
        c = cyc; PU_RX = 1'b0; d = c + 1;
        exp_at(d + 5, "s5_idle", O(0,0,0,0,0,0,0,3'd0));
        wait_cyc(d + 7);

        // Drop during BIAS at relative edge 5
        c = cyc; PU_RX = 1'b1; e = c + 1;
        exp_at(e + 3, "s6_bias", O(1,0,0,0,0,0,0,3'd1));
        wait_cyc(e + 3);
        PU_RX = 1'b0;
        exp_at(e + 4, "s6_off",     O(1,0,0,0,0,0,0,3'd5));
        exp_at(e + 8, "s6_off_end", O(1,0,0,0,0,0,0,3'd5));
        exp_at(e + 9, "s6_idle",    O(0,0,0,0,0,0,0,3'd0));
        wait_cyc(e + 11);

        chk("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_pwr_seq.md
Name: rf_pwr_seq

Overview:
Half-duplex transceiver power sequencer. Arbitrates RX and TX power-up requests for one shared bias/PLL resource. Steps the shared supplies and then the selected chain through timed settle intervals, and reports per-direction ready. Sits between the mode-control logic (PU_RX/PU_TX) and the analog enable pins; the existing RX power-up controller becomes a client of it.

Parameters:
CW, 16, width of the shared settle down-counter
T_BIAS, 10, bias settle time in CLK cycles (≥1)
T_PLL, 50, PLL lock settle time in CLK cycles (≥1)
T_CHAIN, 20, LNA/PA chain settle time in CLK cycles (≥1)
T_OFF, 5, chain discharge time before regrant or shutdown, in CLK cycles (≥1)

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
PU_RX  in  1  RX power-up request, level, synchronous to CLK
PU_TX  in  1  TX power-up request, level, synchronous to CLK
EN_BIAS  out  1  shared bias enable
EN_PLL  out  1  shared PLL enable
EN_LNA  out  1  RX chain enable
EN_PA  out  1  TX chain enable
RDY_RX  out  1  RX chain powered and settled
RDY_TX  out  1  TX chain powered and settled
GNT_TX  out  1  current grant: 0 = RX, 1 = TX
BUSY  out  1  state ≠ IDLE
STATE  out  3  state code, for debug

Behaviour:
- Reset: RST_N low forces state IDLE, counter 0, and all outputs 0 immediately, independent of CLK. This applies mid-sequence as well.
- All outputs are registered. There are no combinational paths from PU_* to outputs.
- States and codes: IDLE=0, BIAS=1, PLL=2, CHAIN=3, ACTIVE=4, OFF=5. Codes 6 and 7 are illegal and return to IDLE on the next edge.
- Counter: loaded with T_x−1 on entry to a timed state. It decrements each cycle, and the state exits on the edge where counter==0. Each timed state therefore lasts exactly T_x cycles.
- IDLE: on a request, grant it (arbitration below), assert EN_BIAS, and go to BIAS.
- BIAS → PLL: assert EN_PLL.
- PLL → CHAIN: assert EN_LNA if GNT_TX=0, else EN_PA.
- CHAIN → ACTIVE: assert RDY_RX or RDY_TX per grant.
- Latency: the request is sampled high at edge 1. RDY rises after edge 1+T_BIAS+T_PLL+T_CHAIN, which is edge 81 at defaults.
- Drop: in BIAS, PLL, CHAIN or ACTIVE, the granted request low at an edge triggers the following on that edge:
  - clear the chain enable and RDY;
  - keep EN_BIAS/EN_PLL at their current values;
  - go to OFF.
  - When the drop happens in BIAS or PLL (chain not yet enabled), OFF is still entered.
- OFF, at expiry:
  - if any request is high and EN_PLL=1: regrant per arbitration and go directly to CHAIN (warm switch, skips BIAS/PLL);
  - if any request is high and EN_PLL=0: regrant and go to BIAS;
  - if no request is high: clear EN_BIAS and EN_PLL on the same edge and go to IDLE.
- No preemption: the non-granted request is ignored until the granted request drops and OFF expires.
- Mutual exclusion: EN_LNA and EN_PA are never both 1. RDY_RX and RDY_TX are never both 1.
- Arbitration (default): fixed priority, RX wins when both requests are high at the grant decision.
- GNT_TX changes only at grant decisions (IDLE exit, OFF exit). It holds its value in IDLE.
- Requests are level-sensitive. A request pulse shorter than one cycle that is not sampled has no effect.

Optional Feature:
RF_SEQ_RR_EN
- Defined: round-robin arbitration. When both requests are high at a grant decision, the direction not granted last wins. The last-grant flag resets to TX, so RX wins the first tie.
- Undefined: fixed RX priority as above.
- Single-request behaviour and all timing are identical in both builds.

Test Plan:
- Reset, then PU_RX=1 from edge 1 -> EN_BIAS rises after edge 1, EN_PLL after edge 11, EN_LNA after edge 61, RDY_RX after edge 81; GNT_TX=0 and STATE=4 throughout active.
- Active RX, drop PU_RX with PU_TX low -> RDY_RX and EN_LNA low after that edge; EN_BIAS and EN_PLL low exactly 5 edges later; STATE=0.
- Active RX, PU_TX=1 raised first, then PU_RX dropped -> OFF for 5 cycles, EN_PA high after the 5th edge, RDY_TX 20 edges after that; EN_LNA and EN_PA never overlap.
- PU_RX and PU_TX both high in IDLE -> RX granted. Repeat the tie after RX releases: RX again in the default build, TX with RF_SEQ_RR_EN.
- RST_N pulsed low while in PLL (edge 30) -> all outputs 0 without a clock edge. With PU_RX still high after release, the full 81-edge sequence restarts.
- PU_RX dropped during BIAS (edge 5) -> EN_LNA never asserts; OFF for 5 cycles, then IDLE with all outputs 0.
